dffnrsnq_pipe: RTL and testbench
================================

DFFNRSNQ_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dffnrsnq_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: number of pipeline stages; SHALL be >= 1.
REQ-003 Parameter RVAL, default {WIDTH{1'b0}}: stage data value loaded by reset.
REQ-004 Parameter SVAL, default {WIDTH{1'b1}}: stage data value loaded by set.
REQ-005 CLKN  input  1  clock; all state SHALL update on its falling edge only.
REQ-006 R  input  1  reset; one clock, reset synchronous and active-high; sampled on the CLKN falling edge.
REQ-007 SETN  input  1  synchronous active-low set; sampled on the CLKN falling edge.
REQ-008 EN  input  1  advance enable; the output stage is consumed when high.
REQ-009 D  input  WIDTH  input data.
REQ-010 DV  input  1  input data valid.
REQ-011 RDY  output  1  input accepted this edge; combinational.
REQ-012 Q  output  WIDTH  last-stage data; registered.
REQ-013 QV  output  1  last-stage valid; registered.
REQ-014 CNT  output  $clog2(DEPTH+1)  number of valid stages; registered.

Function
REQ-015 The block SHALL hold DEPTH stages, each with WIDTH data bits and one valid bit; stage DEPTH-1 drives Q/QV.
REQ-016 Update priority at each CLKN falling edge SHALL be: R, then SETN low, then normal operation.
REQ-017 When SETN=0 and R=0, every stage SHALL load SVAL with valid=0, and CNT SHALL become 0.
REQ-018 When EN=1 in normal operation, stage 0 SHALL load D/DV, stage i SHALL load stage i-1, RDY=1, and latency D->Q SHALL be exactly DEPTH falling edges.
REQ-019 When EN=0 in normal operation without the configuration feature, all stages SHALL hold and RDY=0.
REQ-020 CNT SHALL update as CNT + (DV & RDY) - (EN & QV), computed in CNT width; CNT SHALL never exceed DEPTH or underflow.
REQ-021 CNT SHALL equal the population count of the valid bits at every edge; a mismatch is a design error.
REQ-022 D SHALL be captured regardless of DV; only the valid bits and CNT depend on DV.
REQ-023 DEPTH=1: Q/QV SHALL update directly from D/DV on each accepting edge.
REQ-024 X on R, SETN or EN SHALL drive all stage data and valid bits to X, mirroring cell pessimism.

Reset
REQ-025 When R=1 at a CLKN falling edge, every stage SHALL load RVAL with valid=0 and CNT=0, regardless of SETN, EN and DV.
REQ-026 After reset: Q=RVAL, QV=0, CNT=0, and RDY=EN.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight data on that edge; there is no asynchronous path.

Configuration
REQ-028 Macro GF180MCU_FD_SC_MCU9T5V0_DFFNRSNQ_PIPE_COLLAPSE_EN SHALL compile in bubble collapse.
REQ-029 With the macro defined and EN=0, stage i (i >= 1) SHALL load stage i-1 when any stage k >= i is invalid.
REQ-030 With the macro defined and EN=0, stage 0 SHALL load D/DV when any stage is invalid, and RDY SHALL be EN | (CNT < DEPTH).
REQ-031 With the macro defined and EN=0, the last stage is never consumed, so no valid data SHALL be lost or duplicated.
REQ-032 Without the macro, REQ-019 behaviour SHALL apply and RDY SHALL equal EN.

Verification
REQ-033 WIDTH=8, DEPTH=4, R=1 for 2 edges, then R=0 -> Q=8'h00, QV=0, CNT=0.
REQ-034 EN=1 with D=8'hA5/DV=1 on edge 1, then DV=0 -> Q=8'hA5 and QV=1 after exactly the 4th falling edge, CNT=1 then 0.
REQ-035 SETN=0 for 1 edge with a full pipe (CNT=4) -> Q=8'hFF, QV=0, CNT=0; with R=1 on the same edge -> Q=8'h00.
REQ-036 Stream 8'h01..8'h06 with EN toggling 1,0,1 every edge, no macro -> output order 01..06 with no loss or duplicate, RDY==EN.
REQ-037 Macro defined, EN=0, feed 8'h11,8'h22,8'h33,8'h44,8'h55 with DV=1 -> first four accepted, CNT=4, RDY=0 on the fifth, QV=1, Q=8'h11.
REQ-038 Random EN/DV/SETN/R over 10k edges -> CNT always equals the valid-bit population count, and a scoreboard matches the Q sequence.

Source files
------------

// File: rtl/dffnrsnq_pipe.sv
// dffnrsnq_pipe: falling-edge valid/data pipeline built from set/reset flop stages.
// Each stage holds WIDTH data bits and one valid bit, and stage DEPTH-1 drives Q/QV.
// R (sync, active-high) takes priority over SETN (sync, active-low), which takes
// priority over normal shifting. CNT tracks how many stages hold valid data.
// Optional feature: define GF180MCU_FD_SC_MCU9T5V0_DFFNRSNQ_PIPE_COLLAPSE_EN to let
// stages close bubbles while EN is low.

// One pipeline stage. xp is 0 in hardware but goes X in simulation when a control
// input is X, so every branch pushes X into the stored value the way the cell model does.
module dffnrsnq_pipe_stage #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RVAL  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SVAL  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setn,
  input  logic             ld,
  input  logic             xp,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d,
  output logic             v
);

  // stage register: reset, then set, then load or hold
  always_ff @(negedge clk) begin
    if (rst) begin
      d <= RVAL ^ {WIDTH{xp}};
      v <= xp;
    end else if (!setn) begin
      d <= SVAL ^ {WIDTH{xp}};
      v <= xp;
    end else if (ld) begin
      d <= d_in ^ {WIDTH{xp}};
      v <= v_in ^ xp;
    end else begin
      d <= d ^ {WIDTH{xp}};
      v <= v ^ xp;
    end
  end

endmodule

module dffnrsnq_pipe #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] RVAL  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SVAL  = {WIDTH{1'b1}}
) (
  input  logic                       CLKN,
  input  logic                       R,
  input  logic                       SETN,
  input  logic                       EN,
  input  logic [WIDTH-1:0]           D,
  input  logic                       DV,
  output logic                       RDY,
  output logic [WIDTH-1:0]           Q,
  output logic                       QV,
  output logic [$clog2(DEPTH+1)-1:0] CNT
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] data_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] din;
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0]            vin;
  logic [DEPTH-1:0]            ld;
  logic [CW-1:0]               inc;
  logic [CW-1:0]               dec;
  logic                        xp;

  // Logically zero; X-valued in simulation when R, SETN or EN is X.
  assign xp = (R ^ R) | (SETN ^ SETN) | (EN ^ EN);

`ifdef GF180MCU_FD_SC_MCU9T5V0_DFFNRSNQ_PIPE_COLLAPSE_EN
  logic [DEPTH-1:0] hole;

  // hole[i]: some stage at or above i is empty, so stage i may move up
  always_comb begin
    hole = '0;
    hole[DEPTH-1] = ~vld_pipe[DEPTH-1];
    for (int i = DEPTH-2; i >= 0; i--) hole[i] = hole[i+1] | ~vld_pipe[i];
  end

  assign ld  = {DEPTH{EN}} | hole;
  assign RDY = EN | (CNT < CW'(DEPTH));
`else
  assign ld  = {DEPTH{EN}};
  assign RDY = EN;
`endif

  // Stage 0 takes the input port; D is captured whether or not DV is set.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign din[i] = D;
      assign vin[i] = DV;
    end else begin : g_body
      assign din[i] = data_pipe[i-1];
      assign vin[i] = vld_pipe[i-1];
    end

    dffnrsnq_pipe_stage #(
      .WIDTH (WIDTH),
      .RVAL  (RVAL),
      .SVAL  (SVAL)
    ) u_stage (
      .clk  (CLKN),
      .rst  (R),
      .setn (SETN),
      .ld   (ld[i]),
      .xp   (xp),
      .d_in (din[i]),
      .v_in (vin[i]),
      .d    (data_pipe[i]),
      .v    (vld_pipe[i])
    );
  end

  assign Q   = data_pipe[DEPTH-1];
  assign QV  = vld_pipe[DEPTH-1];
  assign inc = CW'(DV & RDY);
  assign dec = CW'(EN & QV);

  // occupancy counter: +1 on accept, -1 when the output stage is consumed
  always_ff @(negedge CLKN) begin
    if (R)          CNT <= '0;
    else if (!SETN) CNT <= '0;
    else            CNT <= CNT + inc - dec;
  end

endmodule

// File: tb/tb_dffnrsnq_pipe.sv
// Bench for dffnrsnq_pipe (WIDTH=8, DEPTH=4): directed vector table, stream and
// bubble-collapse sequences, then randomized traffic against a slot-array model
// plus an independent FIFO scoreboard of accepted data.
module tb_dffnrsnq_pipe;

  localparam int W  = 8;
  localparam int DP = 4;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DFFNRSNQ_PIPE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  logic         CLKN = 1'b1;
  logic         R = 1'b1, SETN = 1'b1, EN = 1'b0, DV = 1'b0;
  logic [W-1:0] D = '0;
  logic         RDY, QV;
  logic [W-1:0] Q;
  logic [2:0]   CNT;

  int total = 0;
  int bad   = 0;

  dffnrsnq_pipe #(.WIDTH(W), .DEPTH(DP)) dut (
    .CLKN (CLKN), .R (R), .SETN (SETN), .EN (EN), .D (D), .DV (DV),
    .RDY (RDY), .Q (Q), .QV (QV), .CNT (CNT)
  );

  always #5 CLKN = ~CLKN;

  typedef struct {
    logic       r, setn, en;
    logic [7:0] d;
    logic       dv;
    logic [7:0] q;
    logic       qv;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl [17];

  // reference model: slot arrays updated from the rules
  logic [W-1:0] m_d [DP];
  logic         m_v [DP];
  logic [W-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic setn, input logic en,
                       input logic [W-1:0] d, input logic dv);
    R = r; SETN = setn; EN = en; D = d; DV = dv;
  endtask

  task automatic edge_wait();
    @(negedge CLKN);
    #2;
  endtask

  function automatic int pop_m();
    int n = 0;
    for (int i = 0; i < DP; i++) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic model_edge();
    int h;
    if (R) begin
      for (int i = 0; i < DP; i++) begin m_d[i] = '0; m_v[i] = 1'b0; end
    end else if (!SETN) begin
      for (int i = 0; i < DP; i++) begin m_d[i] = '1; m_v[i] = 1'b0; end
    end else if (EN) begin
      for (int i = DP-1; i >= 1; i--) begin m_d[i] = m_d[i-1]; m_v[i] = m_v[i-1]; end
      m_d[0] = D; m_v[0] = DV;
    end else if (COLLAPSE) begin
      h = -1;
      for (int i = 0; i < DP; i++) if (!m_v[i]) h = i;
      if (h >= 0) begin
        for (int i = h; i >= 1; i--) begin m_d[i] = m_d[i-1]; m_v[i] = m_v[i-1]; end
        m_d[0] = D; m_v[0] = DV;
      end
    end
  endtask

  initial begin
    logic [W-1:0] got [$];
    logic [W-1:0] exp_q;
    logic         exp_rdy;
    int           idx;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 3'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b1, 3'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 8'h00, 1'b0, 3'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'hC2, 1'b1, 8'h00, 1'b0, 3'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 8'h00, 1'b0, 3'd3};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'hC4, 1'b1, 8'hC1, 1'b1, 3'd4};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 3'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'hD1, 1'b1, 8'hFF, 1'b0, 3'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'hD2, 1'b1, 8'hFF, 1'b0, 3'd2};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 8'hD3, 1'b1, 8'hFF, 1'b0, 3'd3};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 8'hD4, 1'b1, 8'hD1, 1'b1, 3'd4};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 8'h00, 1'b0, 3'd0};

    // directed vectors: reset, latency, set, reset-over-set
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].setn, tbl[i].en, tbl[i].d, tbl[i].dv);
      #1;
      if (i >= 2) chk($sformatf("vec%0d_rdy", i), 32'(RDY),
                      32'(tbl[i].en | (COLLAPSE && tbl[i-1].cnt < 3'd4)));
      edge_wait();
      chk($sformatf("vec%0d_q", i),   32'(Q),   32'(tbl[i].q));
      chk($sformatf("vec%0d_qv", i),  32'(QV),  32'(tbl[i].qv));
      chk($sformatf("vec%0d_cnt", i), 32'(CNT), 32'(tbl[i].cnt));
    end

    // stream 01..06 with EN toggling; order must be preserved
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    edge_wait();
    edge_wait();
    idx = 0;
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      drive(1'b0, 1'b1, (c % 2 == 0), 8'(idx + 1), (idx < 6));
      #1;
`ifndef GF180MCU_FD_SC_MCU9T5V0_DFFNRSNQ_PIPE_COLLAPSE_EN
      chk("strm_rdy", 32'(RDY), 32'(EN));
`endif
      if (EN && QV) got.push_back(Q);
      if (DV && RDY) idx++;
      edge_wait();
    end
    chk("strm_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++) chk($sformatf("strm_out%0d", i), 32'(got[i]), 32'(i + 1));

`ifdef GF180MCU_FD_SC_MCU9T5V0_DFFNRSNQ_PIPE_COLLAPSE_EN
    // bubble collapse with EN low: four fill, fifth refused
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    edge_wait();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(8'h11 * (i + 1)), 1'b1);
      #1;
      chk($sformatf("col_rdy%0d", i), 32'(RDY), 32'(i < 4));
      edge_wait();
    end
    chk("col_cnt", 32'(CNT), 32'd4);
    chk("col_qv",  32'(QV),  32'd1);
    chk("col_q",   32'(Q),   32'h11);
`endif

    // randomized traffic against model and scoreboard
    for (int n = 0; n < 10000; n++) begin
      drive((n == 0) || ($urandom_range(63) == 0), !($urandom_range(63) == 0),
            $urandom_range(99) < 60, W'($urandom), $urandom_range(99) < 65);
      #1;
      exp_rdy = EN | (COLLAPSE && pop_m() < DP);
      chk("rnd_rdy", 32'(RDY), 32'(exp_rdy));
      if (!R && SETN) begin
        if (EN && QV) begin
          if (sb.size() == 0) chk("sb_empty", 32'(QV), 32'd0);
          else begin
            exp_q = sb.pop_front();
            chk("sb_q", 32'(Q), 32'(exp_q));
          end
        end
        if (DV && exp_rdy) sb.push_back(D);
      end else begin
        sb.delete();
      end
      model_edge();
      edge_wait();
      chk("rnd_cnt", 32'(CNT), 32'(pop_m()));
      chk("rnd_qv",  32'(QV),  32'(m_v[DP-1]));
      chk("rnd_q",   32'(Q),   32'(m_d[DP-1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
